fp_valid_pipe: RTL and testbench

Parametrised valid/tag delay line that runs alongside a fixed-latency arithmetic pipeline (e.g. the FP multiplier) and marks which output samples are real. It generalises a single-bit valid shifter with configurable latency, a sideband tag carried with each operation, a pipeline-enable (stall) input, a synchronous flush, an in-flight counter and a saturating lost-input counter. It sits between the data source valid/tag outputs and the data sink valid input. It shares the datapath clock and enable, so valid and data stay cycle-aligned.

---
 rtl/fp_valid_pipe_if.sv | 33 +++
 rtl/fp_valid_pipe.sv | 82 ++++++++
 tb/tb_fp_valid_pipe.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_valid_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp_valid_pipe_if : valid/tag pipeline handshake bundle       rev 1.0     |
// +--------------------------------------------------------------------------+
interface fp_valid_pipe_if #(
  parameter int LATENCY = 4,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 8
);
  localparam int IW = $clog2(LATENCY + 1);

  logic             en;
  logic             flush;
  logic             vin;
  logic [TAG_W-1:0] tag_in;
  logic             vout;
  logic [TAG_W-1:0] tag_out;
  logic             busy;
  logic [IW-1:0]    inflight;
  logic             lost;
  logic [CNT_W-1:0] lost_cnt;

  modport master (
    output en, flush, vin, tag_in,
    input  vout, tag_out, busy, inflight, lost, lost_cnt
  );

  modport slave (
    input  en, flush, vin, tag_in,
    output vout, tag_out, busy, inflight, lost, lost_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fp_valid_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp_valid_pipe : valid/tag delay line with stall, flush and loss count    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fp_valid_pipe #(
  parameter int LATENCY = 4,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  fp_valid_pipe_if.slave      bus
);
  localparam int IW = $clog2(LATENCY + 1);

  logic [LATENCY-1:0] v_q, v_d;
  logic [TAG_W-1:0]   t_q [LATENCY];
  logic [TAG_W-1:0]   t_d [LATENCY];
  logic [IW-1:0]      inflight_q, inflight_d;
  logic               lost_q, lost_d;
  logic [CNT_W-1:0]   lost_cnt_q, lost_cnt_d;
  logic               accept;
  logic               retire;

  always_comb begin
    accept     = bus.en & ~bus.flush & bus.vin;
    retire     = bus.en & ~bus.flush & v_q[LATENCY-1];
    v_d        = v_q;
    t_d        = t_q;
    inflight_d = inflight_q;
    lost_d     = lost_q;
    lost_cnt_d = lost_cnt_q;

    if (bus.flush) begin
      // Tags are left stale on purpose; tag_out is gated by vout.
      v_d        = '0;
      inflight_d = '0;
    end else if (bus.en) begin
      v_d[0] = bus.vin;
      t_d[0] = bus.tag_in;
      for (int i = 1; i < LATENCY; i++) begin
        v_d[i] = v_q[i-1];
        t_d[i] = t_q[i-1];
      end
      case ({accept, retire})
        2'b10:   inflight_d = inflight_q + IW'(1);
        2'b01:   inflight_d = inflight_q - IW'(1);
        default: inflight_d = inflight_q;
      endcase
    end else if (bus.vin) begin
      lost_d = 1'b1;
      if (lost_cnt_q != '1) begin
        lost_cnt_d = lost_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q        <= '0;
      t_q        <= '{default: '0};
      inflight_q <= '0;
      lost_q     <= 1'b0;
      lost_cnt_q <= '0;
    end else begin
      v_q        <= v_d;
      t_q        <= t_d;
      inflight_q <= inflight_d;
      lost_q     <= lost_d;
      lost_cnt_q <= lost_cnt_d;
    end
  end

  assign bus.vout     = v_q[LATENCY-1];
  assign bus.tag_out  = v_q[LATENCY-1] ? t_q[LATENCY-1] : '0;
  assign bus.busy     = (inflight_q != '0);
  assign bus.inflight = inflight_q;
  assign bus.lost     = lost_q;
  assign bus.lost_cnt = lost_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_fp_valid_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fp_valid_pipe : directed self-checking bench for fp_valid_pipe        |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fp_valid_pipe;
  localparam int LAT = 4;
  localparam int TW  = 8;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_valid_pipe_if #(.LATENCY(LAT), .TAG_W(TW), .CNT_W(CW)) bus ();

  fp_valid_pipe #(.LATENCY(LAT), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Counter must always agree with the number of live stages.
  always @(negedge clk) begin
    if (!rst) begin
      assert ($countones(dut.v_q) == int'(bus.inflight))
        else $error("FAIL inflight_invariant popcount=%0d inflight=%0d",
                    $countones(dut.v_q), bus.inflight);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic flush, input logic vin, input int tag);
    bus.en     = en;
    bus.flush  = flush;
    bus.vin    = vin;
    bus.tag_in = TW'(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 0);
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 0);
    step();
    step();
    checks++;
    if ({bus.vout, bus.tag_out, bus.busy, bus.inflight, bus.lost, bus.lost_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_hold vout=%0b tag=%h busy=%0b inf=%0d lost=%0b cnt=%0d exp all 0",
               bus.vout, bus.tag_out, bus.busy, bus.inflight, bus.lost, bus.lost_cnt);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({bus.vout, bus.tag_out, bus.busy, bus.inflight, bus.lost, bus.lost_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_release vout=%0b tag=%h busy=%0b inf=%0d lost=%0b cnt=%0d exp all 0",
               bus.vout, bus.tag_out, bus.busy, bus.inflight, bus.lost, bus.lost_cnt);
    end
  endtask

  task automatic test_single();
    logic ev;
    int   etag, einf;
    do_reset();
    for (int s = 0; s < 7; s++) begin
      drive(1'b1, 1'b0, s == 0, (s == 0) ? 'h5A : 0);
      step();
      ev   = (s == 3);
      etag = ev ? 'h5A : 0;
      einf = (s <= 3) ? 1 : 0;
      checks++;
      if (bus.vout !== ev || int'(bus.tag_out) != etag || int'(bus.inflight) != einf ||
          bus.busy !== (einf != 0)) begin
        errors++;
        $display("FAIL single s=%0d vout=%0b tag=%h inf=%0d busy=%0b exp vout=%0b tag=%h inf=%0d",
                 s, bus.vout, bus.tag_out, bus.inflight, bus.busy, ev, etag, einf);
      end
    end
  endtask

  task automatic test_streaming();
    logic ev;
    int   etag, einf, acc, ret;
    do_reset();
    for (int s = 0; s < 15; s++) begin
      drive(1'b1, 1'b0, s < 10, s);
      step();
      ev   = (s >= 3) && (s <= 12);
      etag = ev ? s - 3 : 0;
      acc  = (s + 1 < 10) ? s + 1 : 10;
      ret  = (s - 3 < 0) ? 0 : ((s - 3 > 10) ? 10 : s - 3);
      einf = acc - ret;
      checks++;
      if (bus.vout !== ev || int'(bus.tag_out) != etag || int'(bus.inflight) != einf) begin
        errors++;
        $display("FAIL stream s=%0d vout=%0b tag=%h inf=%0d exp vout=%0b tag=%h inf=%0d",
                 s, bus.vout, bus.tag_out, bus.inflight, ev, etag, einf);
      end
    end
  endtask

  task automatic test_stall();
    logic ev;
    int   etag, einf, ecnt;
    do_reset();
    for (int s = 0; s < 9; s++) begin
      if (s == 0)     drive(1'b1, 1'b0, 1'b1, 'h11);
      else if (s < 4) drive(1'b0, 1'b0, 1'b1, 'hFF);
      else            drive(1'b1, 1'b0, 1'b0, 0);
      step();
      ev   = (s == 6);
      etag = ev ? 'h11 : 0;
      einf = (s <= 6) ? 1 : 0;
      ecnt = (s < 3) ? s : 3;
      checks++;
      if (bus.vout !== ev || int'(bus.tag_out) != etag || int'(bus.inflight) != einf ||
          bus.lost !== (s >= 1) || int'(bus.lost_cnt) != ecnt) begin
        errors++;
        $display("FAIL stall s=%0d vout=%0b tag=%h inf=%0d lost=%0b cnt=%0d exp vout=%0b tag=%h inf=%0d cnt=%0d",
                 s, bus.vout, bus.tag_out, bus.inflight, bus.lost, bus.lost_cnt, ev, etag, einf, ecnt);
      end
    end
  endtask

  // Starts with lost_cnt=3 left over from the stall scenario.
  task automatic test_flush();
    logic ev;
    int   etag, einf;
    for (int s = 0; s < 21; s++) begin
      case (s)
        0, 1, 2: drive(1'b1, 1'b0, 1'b1, 'hA0 + s);
        3:       drive(1'b1, 1'b1, 1'b1, 'hEE);
        10:      drive(1'b1, 1'b0, 1'b1, 'hB0);
        16:      drive(1'b1, 1'b0, 1'b1, 'h77);
        17:      drive(1'b0, 1'b1, 1'b1, 'h66);
        default: drive(1'b1, 1'b0, 1'b0, 0);
      endcase
      step();
      ev   = (s == 13);
      etag = ev ? 'hB0 : 0;
      case (s)
        0, 1, 2:            einf = s + 1;
        10, 11, 12, 13, 16: einf = 1;
        default:            einf = 0;
      endcase
      checks++;
      if (bus.vout !== ev || int'(bus.tag_out) != etag || int'(bus.inflight) != einf ||
          bus.busy !== (einf != 0) || bus.lost !== 1'b1 || int'(bus.lost_cnt) != 3) begin
        errors++;
        $display("FAIL flush s=%0d vout=%0b tag=%h inf=%0d busy=%0b cnt=%0d exp vout=%0b tag=%h inf=%0d cnt=3",
                 s, bus.vout, bus.tag_out, bus.inflight, bus.busy, bus.lost_cnt, ev, etag, einf);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 'h99);
    step();
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 1'b0, 1'b1, 'hC0 + s);
      step();
    end
    checks++;
    if (bus.vout !== 1'b1 || bus.tag_out !== 8'hC0 || int'(bus.inflight) != 4 ||
        bus.lost !== 1'b1 || int'(bus.lost_cnt) != 1) begin
      errors++;
      $display("FAIL areset_pre vout=%0b tag=%h inf=%0d lost=%0b cnt=%0d exp 1 c0 4 1 1",
               bus.vout, bus.tag_out, bus.inflight, bus.lost, bus.lost_cnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.vout, bus.tag_out, bus.busy, bus.inflight, bus.lost, bus.lost_cnt} !== '0) begin
      errors++;
      $display("FAIL areset_now vout=%0b tag=%h busy=%0b inf=%0d lost=%0b cnt=%0d exp all 0",
               bus.vout, bus.tag_out, bus.busy, bus.inflight, bus.lost, bus.lost_cnt);
    end
    #1 rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 0);
    for (int s = 0; s < 6; s++) begin
      step();
      checks++;
      if ({bus.vout, bus.tag_out, bus.busy, bus.inflight, bus.lost, bus.lost_cnt} !== '0) begin
        errors++;
        $display("FAIL areset_after s=%0d vout=%0b tag=%h inf=%0d lost=%0b cnt=%0d exp all 0",
                 s, bus.vout, bus.tag_out, bus.inflight, bus.lost, bus.lost_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    int ecnt;
    drive(1'b0, 1'b0, 1'b1, 'h33);
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300) begin
        ecnt = (i < 255) ? i : 255;
        checks++;
        if (int'(bus.lost_cnt) != ecnt || bus.lost !== 1'b1 || bus.vout !== 1'b0) begin
          errors++;
          $display("FAIL saturate i=%0d cnt=%0d lost=%0b vout=%0b exp cnt=%0d lost=1 vout=0",
                   i, bus.lost_cnt, bus.lost, bus.vout, ecnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_stall();
    test_flush();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
